// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: a processor port and a debug/loader port share one dmem port.
// Each access takes an ACCESS cycle followed by a DONE (ack) cycle.
module dmem_arbiter #(
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        p_req_i,
  input  logic [0:31] p_addr_i,
  input  logic [0:31] p_wdata_i,
  input  logic        p_we_i,
  input  logic        p_byte_i,
  input  logic        p_half_i,
  input  logic        p_sext_i,
  output logic        p_ack_o,
  output logic        p_err_o,
  output logic [0:31] p_rdata_o,
  input  logic        d_req_i,
  input  logic [0:31] d_addr_i,
  input  logic [0:31] d_wdata_i,
  input  logic        d_we_i,
  input  logic        d_byte_i,
  input  logic        d_half_i,
  input  logic        d_sext_i,
  output logic        d_ack_o,
  output logic        d_err_o,
  output logic [0:31] d_rdata_o,
  output logic [0:31] addr_to_mem_o,
  output logic        write_enable_to_mem_o,
  output logic        byte_to_mem_o,
  output logic        half_word_to_mem_o,
  output logic        sign_extend_to_mem_o,
  output logic [0:31] data_to_mem_o,
  input  logic [0:31] data_from_mem_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  // Owner of the in-flight access and the round-robin pointer (0 = p, 1 = d).
  logic        grant_q, grant_d;
  logic [0:31] addr_q, addr_d, wdata_q, wdata_d;
  logic        we_q, we_d, byte_q, byte_d, half_q, half_d, sext_q, sext_d;
  logic        err_q, err_d;
  logic [0:31] p_rdata_q, p_rdata_d, d_rdata_q, d_rdata_d;
  logic        grant_valid, grant_sel, misaligned;
  logic [0:31] load_data;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    case (state_q)
      StIdle: begin
        if (p_req_i && d_req_i) begin
          grant_valid = 1'b1;
          grant_sel   = ~grant_q;
        end else if (p_req_i || d_req_i) begin
          grant_valid = 1'b1;
          grant_sel   = d_req_i;
        end
      end
      // The acked requester is ignored; only the other side may be granted back-to-back.
      StDone: begin
        grant_sel   = ~grant_q;
        grant_valid = grant_q ? p_req_i : d_req_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: state_d = grant_valid ? StAccess : StIdle;
      StAccess:       state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  assign misaligned = !byte_q && (half_q ? addr_q[31] : (addr_q[30:31] != 2'b00));
  assign load_data  = (we_q && misaligned) ? '0 : data_from_mem_i;

  always_comb begin
    grant_d   = grant_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    byte_d    = byte_q;
    half_d    = half_q;
    sext_d    = sext_q;
    err_d     = err_q;
    p_rdata_d = p_rdata_q;
    d_rdata_d = d_rdata_q;
    if (grant_valid) begin
      grant_d = grant_sel;
      addr_d  = grant_sel ? d_addr_i  : p_addr_i;
      wdata_d = grant_sel ? d_wdata_i : p_wdata_i;
      we_d    = grant_sel ? d_we_i    : p_we_i;
      byte_d  = grant_sel ? d_byte_i  : p_byte_i;
      half_d  = grant_sel ? d_half_i  : p_half_i;
      sext_d  = grant_sel ? d_sext_i  : p_sext_i;
    end
    if (state_q == StAccess) begin
      err_d = misaligned;
      if (grant_q) d_rdata_d = load_data;
      else         p_rdata_d = load_data;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      grant_q   <= ~RESET_PRIO;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      byte_q    <= 1'b0;
      half_q    <= 1'b0;
      sext_q    <= 1'b0;
      err_q     <= 1'b0;
      p_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      byte_q    <= byte_d;
      half_q    <= half_d;
      sext_q    <= sext_d;
      err_q     <= err_d;
      p_rdata_q <= p_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Mem port is driven purely from state, so reset drops write enable asynchronously.
  always_comb begin
    p_ack_o               = (state_q == StDone) && !grant_q;
    d_ack_o               = (state_q == StDone) && grant_q;
    p_err_o               = p_ack_o && err_q;
    d_err_o               = d_ack_o && err_q;
    p_rdata_o             = p_rdata_q;
    d_rdata_o             = d_rdata_q;
    addr_to_mem_o         = '0;
    write_enable_to_mem_o = 1'b0;
    byte_to_mem_o         = 1'b0;
    half_word_to_mem_o    = 1'b0;
    sign_extend_to_mem_o  = 1'b0;
    data_to_mem_o         = '0;
    if (state_q == StAccess) begin
      addr_to_mem_o         = addr_q;
      write_enable_to_mem_o = we_q && !misaligned;
      byte_to_mem_o         = byte_q;
      half_word_to_mem_o    = half_q;
      sign_extend_to_mem_o  = sext_q;
      data_to_mem_o         = wdata_q;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter RESET_PRIO, default 0; the requester (0 = processor port p_, 1 = debug/loader port d_) that wins the first simultaneous request after reset SHALL be set by this parameter.
REQ-002 Port clock, in, 1: single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, in, 1: asynchronous, active-low reset; reset is asserted when reset = 0.
REQ-004 Ports p_req/d_req, in, 1 each: access request, held high until the matching ack.
REQ-005 Ports p_addr/d_addr, in, 32 each: byte address, bit 0 MSB.
REQ-006 Ports p_wdata/d_wdata, in, 32 each: store data.
REQ-007 Ports p_we/d_we, p_byte/d_byte, p_half/d_half, p_sext/d_sext, in, 1 each: write, byte size, half-word size and sign-extend qualifiers.
REQ-008 Ports p_ack/d_ack, out, 1 each: one-cycle completion pulse.
REQ-009 Ports p_err/d_err, out, 1 each: misalignment flag, valid only while the matching ack is high.
REQ-010 Ports p_rdata/d_rdata, out, 32 each: registered load data, valid while the matching ack is high.
REQ-011 Ports addr_to_mem (32), write_enable_to_mem (1), byte_to_mem (1), half_word_to_mem (1), sign_extend_to_mem (1), data_to_mem (32), all out: the single dmem port.
REQ-012 Port data_from_mem, in, 32: combinational dmem read data.

Function
REQ-013 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-014 In IDLE, when any req is high, the block SHALL latch the winner's addr, wdata and qualifiers into an access register, record the winner as last_grant, and enter ACCESS on the next edge.
REQ-015 Simultaneous requests in IDLE SHALL be granted to the requester other than last_grant; after reset, last_grant SHALL be such that RESET_PRIO wins.
REQ-016 In ACCESS, the mem outputs SHALL be driven from the access register, and write_enable_to_mem SHALL equal the latched we AND NOT misaligned.
REQ-017 Misaligned means: half set with addr[31] = 1, or neither byte nor half set with addr[30:31] != 0; byte accesses are never misaligned.
REQ-018 At the ACCESS->DONE edge, the block SHALL register data_from_mem into the winner's rdata and register the misaligned result into the winner's err.
REQ-019 On a misaligned write, rdata SHALL be 0 and the memory SHALL NOT be written.
REQ-020 In DONE, the winner's ack SHALL be 1 for exactly one cycle; the loser's ack and err SHALL be 0.
REQ-021 In DONE, the acked requester's req SHALL be ignored, and if the other req is high it SHALL be latched and granted directly (DONE->ACCESS); otherwise the FSM SHALL go DONE->IDLE.
REQ-022 Latency: req sampled in IDLE at edge N -> ACCESS cycle N+1 -> ack in cycle N+2; peak throughput is one access per 2 cycles under alternating load.
REQ-023 Outside ACCESS, all mem outputs SHALL be 0.
REQ-024 Only one requester SHALL ever drive the mem port in a cycle, and the two acks SHALL never be high together.
REQ-025 rdata of the non-served requester SHALL hold its previous value.
REQ-026 Request attributes changing after grant SHALL NOT affect the in-flight access.
REQ-027 A req dropped before its ack SHALL still complete if already granted; if not yet granted, it SHALL be dropped silently.

Reset
REQ-028 While reset = 0, the FSM SHALL be in IDLE, all acks, errs and rdata SHALL be 0, all mem outputs SHALL be 0, and last_grant SHALL select RESET_PRIO.
REQ-029 Reset asserted during ACCESS or DONE SHALL abort the access immediately: no ack shall be produced, write_enable_to_mem SHALL drop asynchronously, and no write shall complete after release.
REQ-030 After reset release, the first grant SHALL occur no earlier than the first rising edge at which reset = 1.

Verification
REQ-031 Processor-only load: p_req with addr 0x10 and word size, dmem[0x10..0x13] = DEADBEEF -> p_ack in cycle N+2 with p_rdata = 0xDEADBEEF, p_err = 0.
REQ-032 Simultaneous p_req and d_req held high with RESET_PRIO = 0 -> grant order p, d, p, d; acks alternate every 2 cycles; the two acks never overlap.
REQ-033 d_ word store of 0x12345678 to 0x20, then p_ byte load with sext from 0x20 -> p_rdata = 0x00000012.
REQ-034 p_ half store to 0x21 -> p_err = 1 with ack, write_enable_to_mem = 0 throughout, dmem unchanged.
REQ-035 reset driven low mid-ACCESS of a d_ store -> write_enable_to_mem drops within the same cycle, no d_ack, dmem unchanged; after release, p_ wins the first simultaneous request.
REQ-036 d_addr and d_wdata changed the cycle after grant -> the original values are written; the new values are ignored until the next request.
